sram_controller_mw: RTL and testbench
=====================================

// Module: sram_controller_mw
// PURPOSE
//   Async-SRAM controller, successor of the byte-wide controller: parametrised external
//   data width (8/16), programmable wait states, explicit setup/strobe phases per beat.
//   Sits between the system bus (req/resp/fault, `BUS_WIDTH data, `BUS_ACC_* size) and the
//   board SRAM pins via the IO-ring direction control.
// PARAMETERS
//   SRAM_AW   19   external SRAM word-address width
//   SRAM_DW   8    external data width; legal values 8 or 16
//   WAIT_CYC  0    extra strobe cycles per beat, 0..7
// PORTS
//   clk            in   1               system clock
//   rstn           in   1               asynchronous active-low reset
//   addr           in   `SRAM_VA_WIDTH  byte address
//   w_rb           in   1               1=write, 0=read
//   acc            in   `BUS_ACC_WIDTH  access size (`BUS_ACC_1B/2B/4B)
//   wdata          in   `BUS_WIDTH      write data, byte k -> addr+k
//   req            in   1               request strobe, one cycle
//   rdata          out  `BUS_WIDTH      read data, byte k <- addr+k, unused bytes 0
//   resp           out  1               completion pulse, one cycle
//   fault          out  1               combinational reject of this cycle's req
//   sram_ce_bar    out  1               chip enable, low only while busy
//   sram_oe_bar    out  1               output enable, low in read STROBE only
//   sram_we_bar    out  1               write enable, low in write STROBE only
//   sram_be_bar    out  SRAM_DW/8       byte-lane enables, active low
//   sram_data_dir  out  1               `IOR_DIR_OUT during write beats, else `IOR_DIR_IN
//   sram_data_in   in   SRAM_DW         pad input data
//   sram_data_out  out  SRAM_DW         pad output data
//   sram_addr      out  SRAM_AW         word address (byte addr >> log2(SRAM_DW/8))
// BEHAVIOUR
//   - Reset (async, any state): FSM=IDLE; resp=0, rdata=0, ce/oe/we/be_bar all 1,
//     dir=IN, sram_addr=0. Strobes release immediately, not at the next edge.
//   - fault = req & (misaligned | state!=IDLE); misaligned: 2B on odd addr, 4B on addr[1:0]!=0.
//     Faulted req is dropped, no state change, no resp.
//   - Accept: req & ~fault in IDLE latches w_rb, addr, acc, wdata; beats = bytes/(SRAM_DW/8),
//     min 1; rdata cleared to 0 at accept.
//   - FSM: IDLE -> SETUP -> STROBE(1+WAIT_CYC cycles) -> SETUP (more beats) | DONE -> IDLE.
//     SETUP: addr/be/data_out driven, dir set, oe/we high. STROBE: oe (read) or we (write) low.
//     DONE: resp=1 for exactly one cycle.
//   - Read data sampled at the edge ending the last STROBE cycle of each beat, into byte
//     lanes of rdata by beat index.
//   - Latency: req in cycle 0 -> resp in cycle beats*(2+WAIT_CYC)+1.
//   - SRAM_DW=16, 1B access: be_bar selects lane addr[0]; read byte from that lane
//     returned in rdata[7:0]; write drives wdata[7:0] on both lanes.
//   - Beat word address = latched word addr + beat; no wrap check (caller-aligned).
//   - Wait counter is 3 bits, reloads each beat; WAIT_CYC=0 gives a 1-cycle strobe.
// STRUCTURE
//   - `BUS_ACC_*, `BUS_WIDTH, `SRAM_VA_WIDTH, `IOR_DIR_* remain in the shared defines
//     header; add FSM state encodings `SRAMC_ST_* there.
//   - One sub-module: sram_lane_mux (beat/lane -> data_out, be_bar, rdata byte steering).
//   - Top holds FSM, beat counter, wait counter, request latch.
// TESTING
//   - DW=8, W=0: read 4B @0x100, SRAM holds 11,22,33,44 -> resp cycle 9, rdata=0x44332211.
//   - DW=16, W=1: write 4B 0xA1B2C3D4 @0x200 -> words 0x100=C3D4, 0x101=A1B2; we low 2 cycles/beat.
//   - DW=16: read 1B @0x203 -> be_bar=2'b01, rdata=0x000000<hi byte of word 0x101>.
//   - Misaligned 2B @0x101 -> fault=1 same cycle, no resp, FSM stays IDLE.
//   - req during busy -> fault=1, in-flight access completes unchanged.
//   - rstn low mid-STROBE of write -> we_bar/ce_bar high same cycle, resp never pulses.

Source files
------------

// File: rtl/sram_controller_mw_pkg.sv
// Shared bus/SRAM constants, FSM state encodings and access-size helpers
// for the multi-width async-SRAM controller.
package sram_controller_mw_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int SRAM_VA_WIDTH = 20;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [1:0] BUS_ACC_1B = 2'd0;
  localparam logic [1:0] BUS_ACC_2B = 2'd1;
  localparam logic [1:0] BUS_ACC_4B = 2'd2;

  localparam logic IOR_DIR_IN  = 1'b0;
  localparam logic IOR_DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    SRAMC_ST_IDLE,
    SRAMC_ST_SETUP,
    SRAMC_ST_STROBE,
    SRAMC_ST_DONE
  } sramc_state_e;

  function automatic logic misaligned(
    input logic [1:0] acc,
    input logic [1:0] a
  );
    return ((acc == BUS_ACC_2B) && a[0]) ||
           ((acc == BUS_ACC_4B) && (a != 2'b00));
  endfunction

  // Index of the final beat: bytes / lanes - 1, never below 0.
  function automatic logic [1:0] last_beat(
    input logic [1:0] acc,
    input logic       wide
  );
    logic [1:0] r;
    r = 2'd0;
    if (acc == BUS_ACC_2B) r = wide ? 2'd0 : 2'd1;
    if (acc == BUS_ACC_4B) r = wide ? 2'd1 : 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/sram_controller_mw_lane_mux.sv
// sram_lane_mux: beat/lane steering of write data, byte enables and read bytes.
// Ports: acc/lane/wdata/beats in, pad din in, data_out/be_bar/rdata_o out.
module sram_lane_mux
  import sram_controller_mw_pkg::*;
#(
  parameter int SRAM_DW = 8
) (
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  input  logic                     lane,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic [1:0]               drv_beat,
  input  logic [1:0]               cap_beat,
  input  logic [SRAM_DW-1:0]       din,
  input  logic [BUS_WIDTH-1:0]     rdata_i,
  output logic [SRAM_DW-1:0]       data_out,
  output logic [SRAM_DW/8-1:0]     be_bar,
  output logic [BUS_WIDTH-1:0]     rdata_o
);

  localparam int NL = SRAM_DW / 8;

  // Single-byte access on a wide bus uses one lane only.
  logic narrow;
  assign narrow = (NL > 1) && (acc == BUS_ACC_1B);

  always_comb begin
    data_out = wdata[SRAM_DW*drv_beat +: SRAM_DW];
    be_bar   = '0;
    rdata_o  = rdata_i;
    if (narrow) begin
      data_out     = {NL{wdata[7:0]}};
      be_bar       = ~(NL'(1) << lane);
      rdata_o[7:0] = lane ? din[SRAM_DW-1 -: 8] : din[7:0];
    end else begin
      rdata_o[SRAM_DW*cap_beat +: SRAM_DW] = din;
    end
  end

endmodule

// File: rtl/sram_controller_mw.sv
// sram_controller_mw: bus req/resp/fault to async SRAM pins, 8/16-bit data,
// setup + (1+WAIT_CYC) strobe cycles per beat, registered pin outputs.
module sram_controller_mw
  import sram_controller_mw_pkg::*;
#(
  parameter int SRAM_AW  = 19,
  parameter int SRAM_DW  = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [SRAM_VA_WIDTH-1:0] addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic                     resp,
  output logic                     fault,
  output logic                     sram_ce_bar,
  output logic                     sram_oe_bar,
  output logic                     sram_we_bar,
  output logic [SRAM_DW/8-1:0]     sram_be_bar,
  output logic                     sram_data_dir,
  input  logic [SRAM_DW-1:0]       sram_data_in,
  output logic [SRAM_DW-1:0]       sram_data_out,
  output logic [SRAM_AW-1:0]       sram_addr
);

  localparam int SH = (SRAM_DW == 16) ? 1 : 0;
  localparam int NL = SRAM_DW / 8;

  sramc_state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [2:0] wait_q, wait_d;
  logic [1:0] last_q, last_d;
  logic w_rb_q, w_rb_d;
  logic [SRAM_VA_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] acc_q, acc_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic resp_q, resp_d;
  logic ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic dir_q, dir_d;
  logic [NL-1:0] be_q, be_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [SRAM_DW-1:0] dout_q, dout_d;

  logic accept, strobe_end, busy_d;
  logic [SRAM_DW-1:0] mux_dout;
  logic [NL-1:0] mux_be;
  logic [BUS_WIDTH-1:0] mux_rdata;

  assign fault = req &
    (misaligned(acc, addr[1:0]) | (state_q != SRAMC_ST_IDLE));
  assign accept = req & ~fault;
  assign strobe_end = (state_q == SRAMC_ST_STROBE) && (wait_q == 3'd0);

  always_comb begin
    w_rb_d  = w_rb_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (accept) begin
      w_rb_d  = w_rb;
      addr_d  = addr;
      acc_d   = acc;
      wdata_d = wdata;
      last_d  = last_beat(acc, SRAM_DW == 16);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    unique case (state_q)
      SRAMC_ST_IDLE: begin
        if (accept) begin
          beat_d  = 2'd0;
          state_d = SRAMC_ST_SETUP;
        end
      end
      SRAMC_ST_SETUP: begin
        wait_d  = 3'(WAIT_CYC);
        state_d = SRAMC_ST_STROBE;
      end
      SRAMC_ST_STROBE: begin
        if (!strobe_end) begin
          wait_d = wait_q - 3'd1;
        end else if (beat_q == last_q) begin
          state_d = SRAMC_ST_DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = SRAMC_ST_SETUP;
        end
      end
      SRAMC_ST_DONE: state_d = SRAMC_ST_IDLE;
      default: state_d = SRAMC_ST_IDLE;
    endcase
  end

  sram_lane_mux #(
    .SRAM_DW(SRAM_DW)
  ) u_lane_mux (
    .acc     (acc_d),
    .lane    (addr_d[0]),
    .wdata   (wdata_d),
    .drv_beat(beat_d),
    .cap_beat(beat_q),
    .din     (sram_data_in),
    .rdata_i (rdata_q),
    .data_out(mux_dout),
    .be_bar  (mux_be),
    .rdata_o (mux_rdata)
  );

  // Pins are computed from the next state so they are flop outputs
  // that line up with the state they belong to.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) rdata_d = '0;
    else if (strobe_end && !w_rb_q) rdata_d = mux_rdata;
    busy_d  = (state_d == SRAMC_ST_SETUP) ||
              (state_d == SRAMC_ST_STROBE);
    resp_d  = (state_d == SRAMC_ST_DONE);
    ce_d    = ~busy_d;
    oe_d    = ~((state_d == SRAMC_ST_STROBE) && !w_rb_d);
    we_d    = ~((state_d == SRAMC_ST_STROBE) && w_rb_d);
    dir_d   = (busy_d && w_rb_d) ? IOR_DIR_OUT : IOR_DIR_IN;
    be_d    = busy_d ? mux_be : '1;
    saddr_d = saddr_q;
    dout_d  = dout_q;
    if (busy_d) begin
      saddr_d = addr_d[SH +: SRAM_AW] + SRAM_AW'(beat_d);
      dout_d  = mux_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SRAMC_ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      last_q  <= '0;
      w_rb_q  <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      dir_q   <= IOR_DIR_IN;
      be_q    <= '1;
      saddr_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      w_rb_q  <= w_rb_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dir_q   <= dir_d;
      be_q    <= be_d;
      saddr_q <= saddr_d;
      dout_q  <= dout_d;
    end
  end

  assign rdata         = rdata_q;
  assign resp          = resp_q;
  assign sram_ce_bar   = ce_q;
  assign sram_oe_bar   = oe_q;
  assign sram_we_bar   = we_q;
  assign sram_be_bar   = be_q;
  assign sram_data_dir = dir_q;
  assign sram_data_out = dout_q;
  assign sram_addr     = saddr_q;

endmodule

// File: tb/tb_sram_controller_mw.sv
// Bench for sram_controller_mw: an 8-bit/no-wait and a 16-bit/1-wait instance,
// each with its own SRAM array, checked cycle by cycle against a transaction model.
module tb_sram_controller_mw;
  import sram_controller_mw_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic req_i [2];
  logic w_i [2];
  logic [1:0] acc_i [2];
  logic [19:0] addr_i [2];
  logic [31:0] wdata_i [2];
  logic [31:0] rdata_o [2];
  logic resp_o [2];
  logic fault_o [2];
  logic ce_o [2];
  logic oe_o [2];
  logic we_o [2];
  logic dir_o [2];
  logic [18:0] sa_o [2];
  logic be8;
  logic [1:0] be16;
  logic [7:0] din8, dout8;
  logic [15:0] din16, dout16;

  sram_controller_mw #(.SRAM_AW(19), .SRAM_DW(8), .WAIT_CYC(0)) u_d8 (
    .clk(clk), .rstn(rstn), .addr(addr_i[0]), .w_rb(w_i[0]),
    .acc(acc_i[0]), .wdata(wdata_i[0]), .req(req_i[0]),
    .rdata(rdata_o[0]), .resp(resp_o[0]), .fault(fault_o[0]),
    .sram_ce_bar(ce_o[0]), .sram_oe_bar(oe_o[0]), .sram_we_bar(we_o[0]),
    .sram_be_bar(be8), .sram_data_dir(dir_o[0]),
    .sram_data_in(din8), .sram_data_out(dout8), .sram_addr(sa_o[0])
  );

  sram_controller_mw #(.SRAM_AW(19), .SRAM_DW(16), .WAIT_CYC(1)) u_d16 (
    .clk(clk), .rstn(rstn), .addr(addr_i[1]), .w_rb(w_i[1]),
    .acc(acc_i[1]), .wdata(wdata_i[1]), .req(req_i[1]),
    .rdata(rdata_o[1]), .resp(resp_o[1]), .fault(fault_o[1]),
    .sram_ce_bar(ce_o[1]), .sram_oe_bar(oe_o[1]), .sram_we_bar(we_o[1]),
    .sram_be_bar(be16), .sram_data_dir(dir_o[1]),
    .sram_data_in(din16), .sram_data_out(dout16), .sram_addr(sa_o[1])
  );

  // SRAM devices
  logic [7:0] mem8 [4096];
  logic [15:0] mem16 [4096];

  function automatic logic [7:0] f8(input int j);
    return 8'(j * 3 + 1);
  endfunction
  function automatic logic [15:0] f16(input int j);
    return 16'(j * 257 + 7);
  endfunction

  assign din8 = (!ce_o[0] && !oe_o[0]) ? mem8[sa_o[0][11:0]] : 8'h00;
  assign din16 = (!ce_o[1] && !oe_o[1]) ? mem16[sa_o[1][11:0]] : 16'h0;

  initial begin
    for (int j = 0; j < 4096; j++) begin
      mem8[j] = f8(j);
      mem16[j] = f16(j);
    end
    mem8[256] = 8'h11;
    mem8[257] = 8'h22;
    mem8[258] = 8'h33;
    mem8[259] = 8'h44;
    forever begin
      @(negedge clk);
      if (!ce_o[0] && !we_o[0]) mem8[sa_o[0][11:0]] = dout8;
      if (!ce_o[1] && !we_o[1]) begin
        if (!be16[0]) mem16[sa_o[1][11:0]][7:0] = dout16[7:0];
        if (!be16[1]) mem16[sa_o[1][11:0]][15:8] = dout16[15:8];
      end
    end
  end

  // Transaction model: byte-addressed reference memory per instance
  logic [7:0] ref_b [2][8192];
  bit m_act [2];
  int m_start [2];
  bit m_w [2];
  logic [1:0] m_acc [2];
  logic [19:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_exp [2];
  int wait_of [2] = '{0, 1};
  int lanes_of [2] = '{1, 2};
  int resp_k [2];
  logic [31:0] resp_data [2];
  int we_cnt [2];
  logic [1:0] be_seen [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] a);
    if (a == BUS_ACC_2B) return 2;
    if (a == BUS_ACC_4B) return 4;
    return 1;
  endfunction

  function automatic int nbeats(input int i, input logic [1:0] a);
    int b;
    b = nbytes(a) / lanes_of[i];
    return (b < 1) ? 1 : b;
  endfunction

  task automatic cmp(input int i);
    int per, n, k, beat;
    bit busy, strobe, done;
    logic [1:0] exp_be, act_be;
    logic [15:0] exp_do, act_do;
    logic [18:0] exp_sa;
    per = 2 + wait_of[i];
    n = nbeats(i, m_acc[i]) * per + 1;
    busy = 0; strobe = 0; done = 0; beat = 0; k = 0;
    if (m_act[i]) begin
      k = cyc - m_start[i];
      if (k >= 1 && k < n) begin
        busy = 1;
        beat = (k - 1) / per;
        strobe = ((k - 1) % per) != 0;
      end else if (k == n) begin
        done = 1;
      end
    end
    chk($sformatf("ce%0d", i), ce_o[i], !busy);
    chk($sformatf("oe%0d", i), oe_o[i], !(busy && strobe && !m_w[i]));
    chk($sformatf("we%0d", i), we_o[i], !(busy && strobe && m_w[i]));
    chk($sformatf("dir%0d", i), dir_o[i], busy && m_w[i]);
    chk($sformatf("resp%0d", i), resp_o[i], done);
    if (!we_o[i]) we_cnt[i]++;
    if (resp_o[i] && m_act[i]) resp_k[i] = k;
    if (busy) begin
      exp_sa = 19'((m_addr[i] >> (lanes_of[i] - 1)) + 20'(beat));
      act_be = (i == 0) ? {1'b0, be8} : be16;
      exp_be = 2'b00;
      if (i == 1 && m_acc[i] == BUS_ACC_1B)
        exp_be = m_addr[i][0] ? 2'b01 : 2'b10;
      be_seen[i] = act_be;
      chk($sformatf("addr%0d", i), sa_o[i], exp_sa);
      chk($sformatf("be%0d", i), act_be, exp_be);
      if (m_w[i]) begin
        act_do = (i == 0) ? {8'h0, dout8} : dout16;
        if (i == 0) exp_do = {8'h0, 8'(m_wd[i] >> (8 * beat))};
        else if (m_acc[i] == BUS_ACC_1B) exp_do = {2{m_wd[i][7:0]}};
        else exp_do = 16'(m_wd[i] >> (16 * beat));
        chk($sformatf("dout%0d", i), act_do, exp_do);
      end
    end
    if (done) begin
      chk($sformatf("rdata%0d", i), rdata_o[i], m_exp[i]);
      resp_data[i] = rdata_o[i];
      m_act[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      cmp(0);
      cmp(1);
    end
  end

  task automatic issue(input int i, input bit w, input logic [1:0] a,
                       input logic [19:0] ad, input logic [31:0] wd);
    bit exp_f;
    logic [31:0] e;
    @(posedge clk);
    #1;
    req_i[i] = 1'b1;
    w_i[i] = w;
    acc_i[i] = a;
    addr_i[i] = ad;
    wdata_i[i] = wd;
    exp_f = m_act[i] || (a == BUS_ACC_2B && ad[0]) ||
            (a == BUS_ACC_4B && ad[1:0] != 2'b00);
    #1;
    chk($sformatf("fault%0d_%h", i, ad), fault_o[i], exp_f);
    if (!exp_f) begin
      e = '0;
      for (int b = 0; b < nbytes(a); b++) begin
        if (w) ref_b[i][ad + 20'(b)] = wd[8*b +: 8];
        else e[8*b +: 8] = ref_b[i][ad + 20'(b)];
      end
      m_w[i] = w;
      m_acc[i] = a;
      m_addr[i] = ad;
      m_wd[i] = wd;
      m_exp[i] = e;
      m_start[i] = cyc;
      m_act[i] = 1;
    end
    @(posedge clk);
    #1;
    req_i[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int t = 0; t < 60 && m_act[i]; t++) @(posedge clk);
    if (m_act[i]) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: got busy expected done", i);
      m_act[i] = 0;
    end
    @(posedge clk);
  endtask

  task automatic run(input int i, input bit w, input logic [1:0] a,
                     input logic [19:0] ad, input logic [31:0] wd);
    issue(i, w, a, ad, wd);
    wait_done(i);
  endtask

  task automatic chk_reset_pins();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ce%0d", i), ce_o[i], 1);
      chk($sformatf("rst_oe%0d", i), oe_o[i], 1);
      chk($sformatf("rst_we%0d", i), we_o[i], 1);
      chk($sformatf("rst_dir%0d", i), dir_o[i], 0);
      chk($sformatf("rst_resp%0d", i), resp_o[i], 0);
      chk($sformatf("rst_rdata%0d", i), rdata_o[i], 0);
      chk($sformatf("rst_addr%0d", i), sa_o[i], 0);
    end
    chk("rst_be8", be8, 1);
    chk("rst_be16", be16, 2'b11);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_i[i] = 0; w_i[i] = 0; acc_i[i] = 0;
      addr_i[i] = 0; wdata_i[i] = 0;
      m_act[i] = 0; we_cnt[i] = 0; resp_k[i] = 0;
    end
    for (int j = 0; j < 4096; j++) begin
      logic [15:0] t;
      t = f16(j);
      ref_b[0][j] = f8(j);
      ref_b[0][j + 4096] = f8(j + 4096);
      ref_b[1][2*j] = t[7:0];
      ref_b[1][2*j + 1] = t[15:8];
    end
    ref_b[0][256] = 8'h11;
    ref_b[0][257] = 8'h22;
    ref_b[0][258] = 8'h33;
    ref_b[0][259] = 8'h44;

    #22;
    chk_reset_pins();
    @(posedge clk);
    #3 rstn = 1'b1;

    run(0, 0, BUS_ACC_4B, 20'h100, 0);
    chk("lat8", resp_k[0], 9);
    chk("rd8_4b", resp_data[0], 32'h44332211);

    we_cnt[1] = 0;
    run(1, 1, BUS_ACC_4B, 20'h200, 32'hA1B2C3D4);
    chk("w16_lo", mem16[256], 16'hC3D4);
    chk("w16_hi", mem16[257], 16'hA1B2);
    chk("w16_wecnt", we_cnt[1], 4);
    chk("lat16", resp_k[1], 7);

    run(1, 0, BUS_ACC_1B, 20'h203, 0);
    chk("be16_1b", be_seen[1], 2'b01);
    chk("rd16_1b", resp_data[1], 32'h000000A1);

    run(0, 0, BUS_ACC_2B, 20'h101, 0);
    repeat (3) @(posedge clk);

    issue(0, 0, BUS_ACC_2B, 20'h104, 0);
    issue(0, 1, BUS_ACC_4B, 20'h108, 32'h12345678);
    wait_done(0);

    run(0, 1, BUS_ACC_1B, 20'h105, 32'h000000EE);
    run(0, 1, BUS_ACC_2B, 20'h10A, 32'h0000BEEF);
    run(0, 1, BUS_ACC_4B, 20'h10C, 32'hCAFEF00D);
    run(0, 0, BUS_ACC_4B, 20'h104, 0);
    run(0, 0, BUS_ACC_4B, 20'h108, 0);
    run(0, 0, BUS_ACC_4B, 20'h10C, 0);
    chk("rd8_back", resp_data[0], 32'hCAFEF00D);
    run(0, 0, BUS_ACC_1B, 20'h10D, 0);
    run(0, 0, BUS_ACC_4B, 20'h10E, 0);

    run(1, 0, BUS_ACC_2B, 20'h202, 0);
    chk("rd16_2b", resp_data[1], 32'h0000A1B2);
    run(1, 1, BUS_ACC_1B, 20'h207, 32'h00000055);
    run(1, 1, BUS_ACC_2B, 20'h204, 32'h00001234);
    run(1, 0, BUS_ACC_4B, 20'h204, 0);
    run(1, 0, BUS_ACC_4B, 20'h102, 0);
    run(1, 1, BUS_ACC_1B, 20'h310, 32'h00000077);
    run(1, 0, BUS_ACC_2B, 20'h310, 0);
    chk("rd16_lane0", resp_data[1][7:0], 8'h77);

    issue(1, 1, BUS_ACC_4B, 20'h300, 32'h01020304);
    @(posedge clk);
    #1 chk("pre_rst_we", we_o[1], 0);
    #1 rstn = 1'b0;
    m_act[0] = 0;
    m_act[1] = 0;
    #1;
    chk_reset_pins();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (10) @(posedge clk);

    run(1, 0, BUS_ACC_4B, 20'h200, 0);
    chk("rd16_post_rst", resp_data[1], 32'hA1B2C3D4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
